// File: rtl/arb_1hot3_pkg.sv
// Shared constants and types for the 3-requester one-hot arbiter.
//   NumReq       : number of requesters
//   req_vec_t    : one bit per requester
//   LastGrantRst : last_grant after reset; 3'b100 puts requester 0 first
package arb_1hot3_pkg;

    localparam int unsigned NumReq = 3;

    typedef logic [NumReq-1:0] req_vec_t;

    localparam req_vec_t LastGrantRst = 3'b100;

endpackage

// File: rtl/arb_1hot3_rr_pick3.sv
// Round-robin pick among three requesters. This block is purely combinational.
// The search starts at the index after the previous grant and wraps 2 -> 0.
// Ports:
//   req   : request vector
//   last  : one-hot previous grant. Zero or multi-hot values act like 3'b100.
//   grant : one-hot pick, or zero when nobody requests
module rr_pick3
    import arb_1hot3_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic [NumReq-1:0] last,
    output logic [NumReq-1:0] grant
);

    always_comb begin
        grant = '0;
        case (last)
            3'b001: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            3'b010: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/arb_1hot3.sv
// Three-input round-robin arbiter with a single registered output slot.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   in_valid[2:0]   : requests from requesters 0..2
//   in0, in1, in2   : payloads of requesters 0..2
//   in_ready[2:0]   : one-hot or zero accept strobe
//   out_valid       : the output register holds a payload
//   out_data        : registered payload
//   out_sel[2:0]    : one-hot source tag of out_data; zero when out_valid is low
//   out_ready       : downstream takes out_data this cycle
module arb_1hot3
    import arb_1hot3_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] in_valid,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    output logic [NumReq-1:0] in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [NumReq-1:0] out_sel,
    input  logic              out_ready
);

    logic             enable;
    req_vec_t         grant;
    req_vec_t         last_grant_q;
    logic [WIDTH-1:0] grant_data;

    // The output slot is free when it is empty or is being drained this cycle.
    assign enable = ~out_valid | out_ready;

    rr_pick3 u_pick (
        .req   (in_valid),
        .last  (last_grant_q),
        .grant (grant)
    );

    always_comb begin
        in_ready = '0;
        if (!rst) begin
            in_ready = grant & {NumReq{enable}};
        end
    end

    always_comb begin
        grant_data = '0;
        unique case (grant)
            3'b001:  grant_data = in0;
            3'b010:  grant_data = in1;
            3'b100:  grant_data = in2;
            default: grant_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_sel      <= '0;
            out_data     <= '0;
            last_grant_q <= LastGrantRst;
        end else if (|in_ready) begin
            // A load has priority over a drain, so a transfer can happen every cycle.
            out_valid    <= 1'b1;
            out_sel      <= grant;
            out_data     <= grant_data;
            last_grant_q <= grant;
        end else if (out_valid && out_ready) begin
            // out_data is kept as it is. Consumers ignore it while out_valid is low.
            out_valid <= 1'b0;
            out_sel   <= '0;
        end
    end

endmodule

// File: doc/arb_1hot3.md
ARB_1HOT3 -- requirements
Module: arb_1hot3

Interface
REQ-001 SHALL have parameter WIDTH, default 1, payload width in bits per requester.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  3  request from requesters 0..2.
REQ-005 SHALL have ports in0, in1, in2  input  WIDTH each  payload of requesters 0..2.
REQ-006 SHALL have port in_ready  output  3  one-hot or zero accept strobe; bit i means requester i is taken this cycle.
REQ-007 SHALL have port out_valid  output  1  registered output holds a payload.
REQ-008 SHALL have port out_data  output  WIDTH  registered payload.
REQ-009 SHALL have port out_sel  output  3  registered one-hot tag of the source of out_data; 3'b000 when out_valid=0.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-011 SHALL form internal enable = !out_valid | out_ready, meaning the output register is free.
REQ-012 SHALL compute grant[2:0] combinationally as a round-robin pick among in_valid, searched from the index after last_grant, wrapping 2->0.
REQ-013 SHALL drive in_ready = grant & {3{enable}}, so in_ready is always one-hot or zero.
REQ-014 SHALL, on a cycle with any in_ready bit set, load out_data with the granted input, load out_sel=grant, set out_valid=1 and set last_grant=grant.
REQ-015 SHALL, when out_valid & out_ready and no in_ready bit is set, clear out_valid and out_sel on the next edge.
REQ-016 SHALL hold out_data, out_sel and out_valid stable while out_valid & !out_ready (backpressure); in_ready SHALL be 3'b000 then.
REQ-017 SHALL sustain one transfer per cycle when out_ready is held 1: simultaneous drain and load SHALL replace the register contents.
REQ-018 SHALL have latency of exactly 1 cycle from in_ready[i] to the payload appearing with out_valid=1.
REQ-019 SHALL leave last_grant unchanged on cycles with no grant, including grants blocked by backpressure.
REQ-020 SHALL grant each continuously requesting requester at least once in every 3 consecutive accepts (no starvation).
REQ-021 SHALL keep out_data at its previous value when out_valid=0; it is don't-care to consumers.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set out_valid=0, out_sel=3'b000, out_data=0 and last_grant=3'b100, so requester 0 holds first priority.
REQ-023 SHALL force in_ready=3'b000 while rst=1 and discard any in-flight output payload.
REQ-024 SHALL NOT accept a request on the edge at which rst is sampled high.

Structure
REQ-025 SHALL place the requester count constant (3) and the reset last_grant value in the shared hwlib package.
REQ-026 SHALL implement round-robin pick as one sub-module rr_pick3 (inputs req[3], last[3]; output one-hot grant[3], purely combinational).
REQ-027 SHALL produce out_sel compatible as the sel input of the existing 3-way one-hot mux.

Verification
REQ-028 Reset then in_valid=3'b111, out_ready=1 held -> in_ready sequence 001,010,100,001 on consecutive cycles, with out_sel matching one cycle later.
REQ-029 in_valid=3'b010 only, out_ready=1, in1=8'hA5, WIDTH=8 -> next cycle out_valid=1, out_data=8'hA5, out_sel=3'b010.
REQ-030 Load one item, then out_ready=0 for 4 cycles with in_valid=3'b111 -> out_data and out_sel constant and in_ready=000 throughout; first cycle out_ready=1 -> new grant follows round-robin order.
REQ-031 in_valid=3'b101, last_grant=100 -> grant 001, then 100, then 001 (index 1 skipped without stall).
REQ-032 rst=1 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_sel=000; after release, first grant goes to requester 0 when all request.
REQ-033 Random in_valid/out_ready for 10k cycles with scoreboard -> no payload lost or duplicated, in_ready never multi-hot, max wait per requester at most 3 accepts.
